// File: rtl/loader_pkg.sv
// Shared types for the ROM download loader: the SDRAM write record and the
// write-port FSM states.
package loader_pkg;

  localparam int unsigned BYTE_AW = 25;
  localparam int unsigned WORD_AW = 24;

  typedef struct packed {
    logic [WORD_AW-1:0] addr;
    logic [15:0]        data;
    logic [1:0]         ds;
  } wr_word_t;

  typedef enum logic {
    LD_IDLE,
    LD_REQ
  } ld_state_t;

  function automatic wr_word_t make_word(input logic [WORD_AW-1:0] addr,
                                         input logic [7:0] hi,
                                         input logic [7:0] lo,
                                         input logic [1:0] ds);
    wr_word_t w;
    w.addr = addr;
    w.data = {hi, lo};
    w.ds   = ds;
    return w;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO of SDRAM write records. A push while full is
// refused (caller flags it); the head is read straight from storage.
module loader_fifo
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  wr_word_t                 push_word,
  input  logic                     pop,
  output wr_word_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  wr_word_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    do_push  = push && (count_q != FULL_COUNT);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; cleared pointers make stale entries unreachable.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= push_word;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rom_sdram_loader.sv
// Packs the ioctl byte stream into big-endian 16-bit SDRAM writes, diverts
// high addresses to a PROM port and reports download completion.
module rom_sdram_loader
  import loader_pkg::*;
#(
  parameter logic [24:0] ROM_SIZE   = 25'h0100000,
  parameter logic [23:0] BASE_WORD  = 24'h000000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        rom_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        sdram_req,
  input  logic        sdram_ack,
  output logic [23:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_ds,
  output logic        prom_wr,
  output logic [11:0] prom_addr,
  output logic [7:0]  prom_data,
  output logic        loaded,
  output logic        overflow,
  output logic        seq_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic        dl_q;
  logic        dl_rise, dl_fall, byte_wr, to_prom, pend_live;
  logic [23:0] word_addr;

  logic        pend_valid_q, pend_valid_d;
  logic [7:0]  pend_byte_q, pend_byte_d;
  logic [23:0] pend_addr_q, pend_addr_d;
  logic        ended_q, ended_d;
  logic        loaded_q, loaded_d;
  logic        overflow_q, overflow_d;
  logic        seq_err_q, seq_err_d;
  logic        prom_wr_q, prom_wr_d;
  logic [11:0] prom_addr_q, prom_addr_d;
  logic [7:0]  prom_data_q, prom_data_d;
  ld_state_t   state_q, state_d;
  logic        req_q, req_d;
  wr_word_t    out_q, out_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  wr_word_t    fifo_word, fifo_head;
  logic [CW-1:0] fifo_count;

  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (fifo_push),
    .push_word (fifo_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Byte packer, PROM diverter and status flags.
  always_comb begin
    dl_rise   = rom_download & ~dl_q;
    dl_fall   = ~rom_download & dl_q;
    byte_wr   = ioctl_wr & rom_download;
    to_prom   = ioctl_addr >= ROM_SIZE;
    word_addr = BASE_WORD + ioctl_addr[24:1];
    // A new download forgets any half-word left over from the previous one.
    pend_live = pend_valid_q & ~dl_rise;

    fifo_push    = 1'b0;
    fifo_word    = '0;
    pend_valid_d = pend_live;
    pend_byte_d  = pend_byte_q;
    pend_addr_d  = pend_addr_q;
    seq_err_d    = seq_err_q & ~dl_rise;

    if (dl_fall && pend_live) begin
      fifo_push    = 1'b1;
      fifo_word    = make_word(pend_addr_q, pend_byte_q, 8'h00, 2'b10);
      pend_valid_d = 1'b0;
    end else if (byte_wr && !to_prom) begin
      if (!ioctl_addr[0]) begin
        if (pend_live) begin
          fifo_push = 1'b1;
          fifo_word = make_word(pend_addr_q, pend_byte_q, 8'h00, 2'b10);
        end
        pend_valid_d = 1'b1;
        pend_byte_d  = ioctl_dout;
        pend_addr_d  = word_addr;
      end else begin
        fifo_push    = 1'b1;
        pend_valid_d = 1'b0;
        if (pend_live && pend_addr_q == word_addr) begin
          fifo_word = make_word(word_addr, pend_byte_q, ioctl_dout, 2'b11);
        end else begin
          fifo_word = make_word(word_addr, 8'h00, ioctl_dout, 2'b01);
          if (pend_live) seq_err_d = 1'b1;
        end
      end
    end

    overflow_d = (overflow_q & ~dl_rise) | (fifo_push & fifo_full);

    prom_wr_d   = byte_wr & to_prom;
    prom_addr_d = prom_wr_d ? ioctl_addr[11:0] - ROM_SIZE[11:0] : prom_addr_q;
    prom_data_d = prom_wr_d ? ioctl_dout : prom_data_q;

    ended_d  = ended_q | dl_fall;
    loaded_d = loaded_q | (~rom_download & ~pend_valid_q & (fifo_count == '0)
                           & (state_q == LD_IDLE) & ended_q);
    if (dl_rise) loaded_d = 1'b0;
  end

  // Write port: one request per FIFO word, with a mandatory idle cycle after each ack.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    out_d    = out_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (!fifo_empty) begin
          out_d   = fifo_head;
          req_d   = 1'b1;
          state_d = LD_REQ;
        end
      end
      LD_REQ: begin
        if (sdram_ack) begin
          fifo_pop = 1'b1;
          req_d    = 1'b0;
          state_d  = LD_IDLE;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q         <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_byte_q  <= '0;
      pend_addr_q  <= '0;
      ended_q      <= 1'b0;
      loaded_q     <= 1'b0;
      overflow_q   <= 1'b0;
      seq_err_q    <= 1'b0;
      prom_wr_q    <= 1'b0;
      prom_addr_q  <= '0;
      prom_data_q  <= '0;
      state_q      <= LD_IDLE;
      req_q        <= 1'b0;
      out_q        <= '0;
    end else begin
      dl_q         <= rom_download;
      pend_valid_q <= pend_valid_d;
      pend_byte_q  <= pend_byte_d;
      pend_addr_q  <= pend_addr_d;
      ended_q      <= ended_d;
      loaded_q     <= loaded_d;
      overflow_q   <= overflow_d;
      seq_err_q    <= seq_err_d;
      prom_wr_q    <= prom_wr_d;
      prom_addr_q  <= prom_addr_d;
      prom_data_q  <= prom_data_d;
      state_q      <= state_d;
      req_q        <= req_d;
      out_q        <= out_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = out_q.addr;
  assign sdram_din  = out_q.data;
  assign sdram_ds   = out_q.ds;
  assign prom_wr    = prom_wr_q;
  assign prom_addr  = prom_addr_q;
  assign prom_data  = prom_data_q;
  assign loaded     = loaded_q;
  assign overflow   = overflow_q;
  assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_rom_sdram_loader.sv
// Directed bench for rom_sdram_loader: a PROM vector table plus hand-written
// download sequences against a small acking SDRAM responder.
module tb_rom_sdram_loader;
  import loader_pkg::*;

  localparam logic [24:0] ROM_SIZE = 25'h0100000;

  logic        clk_sys;
  logic        reset;
  logic        rom_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        sdram_req;
  logic        sdram_ack;
  logic [23:0] sdram_addr;
  logic [15:0] sdram_din;
  logic [1:0]  sdram_ds;
  logic        prom_wr;
  logic [11:0] prom_addr;
  logic [7:0]  prom_data;
  logic        loaded;
  logic        overflow;
  logic        seq_err;

  rom_sdram_loader #(
    .ROM_SIZE   (ROM_SIZE),
    .BASE_WORD  (24'h000000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .rom_download (rom_download),
    .ioctl_wr     (ioctl_wr),
    .ioctl_addr   (ioctl_addr),
    .ioctl_dout   (ioctl_dout),
    .sdram_req    (sdram_req),
    .sdram_ack    (sdram_ack),
    .sdram_addr   (sdram_addr),
    .sdram_din    (sdram_din),
    .sdram_ds     (sdram_ds),
    .prom_wr      (prom_wr),
    .prom_addr    (prom_addr),
    .prom_data    (prom_data),
    .loaded       (loaded),
    .overflow     (overflow),
    .seq_err      (seq_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int       n_checks = 0;
  int       n_errors = 0;
  int       ack_delay = 2;
  logic     ack_en = 1'b0;
  wr_word_t log_q[$];

  typedef struct {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic        exp_wr;
    logic [11:0] exp_addr;
    logic [7:0]  exp_data;
  } prom_vec_t;

  prom_vec_t vecs [8];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic wr_word_t exp_word(input logic [23:0] a, input logic [15:0] d,
                                        input logic [1:0] ds);
    wr_word_t w;
    w.addr = a;
    w.data = d;
    w.ds   = ds;
    return w;
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_log(input string name, input int n, input int budget);
    for (int i = 0; i < budget && log_q.size() < n; i++) tick();
    check(name, 64'(log_q.size()), 64'(n));
  endtask

  task automatic wait_loaded(input string name, input int budget);
    for (int i = 0; i < budget && !loaded; i++) tick();
    check(name, 64'(loaded), 64'(1));
  endtask

  task automatic check_log(input string name, input int idx, input wr_word_t w);
    if (idx < log_q.size()) check(name, 64'(log_q[idx]), 64'(w));
    else check(name, 64'(log_q.size()), 64'(idx + 1));
  endtask

  // SDRAM responder: after ack_delay cycles of req, pulse ack once and log the write.
  initial begin
    int cnt;
    cnt = 0;
    sdram_ack = 1'b0;
    forever begin
      tick();
      if (sdram_ack) begin
        sdram_ack = 1'b0;
        cnt = 0;
      end else if (sdram_req && ack_en) begin
        cnt++;
        if (cnt >= ack_delay) begin
          wr_word_t w;
          w.addr = sdram_addr;
          w.data = sdram_din;
          w.ds   = sdram_ds;
          log_q.push_back(w);
          sdram_ack = 1'b1;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    logic early;

    vecs[0] = '{1'b1, 1'b1, ROM_SIZE + 25'd3,      8'h5A, 1'b1, 12'h003, 8'h5A};
    vecs[1] = '{1'b1, 1'b1, ROM_SIZE,              8'h11, 1'b1, 12'h000, 8'h11};
    vecs[2] = '{1'b1, 1'b1, ROM_SIZE + 25'h0FFF,   8'h22, 1'b1, 12'hFFF, 8'h22};
    vecs[3] = '{1'b1, 1'b1, ROM_SIZE + 25'h1000,   8'h33, 1'b1, 12'h000, 8'h33};
    vecs[4] = '{1'b1, 1'b1, 25'h1FFFFFF,           8'h44, 1'b1, 12'hFFF, 8'h44};
    vecs[5] = '{1'b1, 1'b1, ROM_SIZE - 25'd1,      8'h55, 1'b0, 12'h000, 8'h00};
    vecs[6] = '{1'b1, 1'b0, ROM_SIZE + 25'd5,      8'h66, 1'b0, 12'h000, 8'h00};
    vecs[7] = '{1'b0, 1'b1, ROM_SIZE + 25'd5,      8'h77, 1'b0, 12'h000, 8'h00};

    reset        = 1'b1;
    rom_download = 1'b0;
    ioctl_wr     = 1'b0;
    ioctl_addr   = '0;
    ioctl_dout   = '0;
    repeat (3) tick();
    check("reset_req",      64'(sdram_req), 64'(0));
    check("reset_addr",     64'(sdram_addr), 64'(0));
    check("reset_din",      64'(sdram_din), 64'(0));
    check("reset_ds",       64'(sdram_ds), 64'(0));
    check("reset_prom_wr",  64'(prom_wr), 64'(0));
    check("reset_flags",    64'({loaded, overflow, seq_err}), 64'(0));
    reset = 1'b0;
    tick();

    // Four sequential bytes -> two full words, loaded after the download ends.
    ack_en = 1'b1;
    ack_delay = 2;
    log_q.delete();
    rom_download = 1'b1;
    tick();
    send_byte(25'd0, 8'h12);
    send_byte(25'd1, 8'h34);
    send_byte(25'd2, 8'h56);
    send_byte(25'd3, 8'h78);
    rom_download = 1'b0;
    tick();
    wait_log("seq4_count", 2, 60);
    check_log("seq4_w0", 0, exp_word(24'd0, 16'h1234, 2'b11));
    check_log("seq4_w1", 1, exp_word(24'd1, 16'h5678, 2'b11));
    wait_loaded("seq4_loaded", 30);

    // Odd byte count: trailing half-word flushed on the falling edge.
    log_q.delete();
    rom_download = 1'b1;
    tick();
    check("rise_clears_loaded", 64'(loaded), 64'(0));
    send_byte(25'd0, 8'hAA);
    send_byte(25'd1, 8'hBB);
    send_byte(25'd2, 8'hCC);
    rom_download = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 60 && log_q.size() < 2; i++) begin
      if (loaded) early = 1'b1;
      tick();
    end
    check("tail_loaded_early", 64'(early | loaded), 64'(0));
    check("tail_count", 64'(log_q.size()), 64'(2));
    check_log("tail_w0", 0, exp_word(24'd0, 16'hAABB, 2'b11));
    check_log("tail_w1", 1, exp_word(24'd1, 16'hCC00, 2'b10));
    wait_loaded("tail_loaded", 30);

    // PROM diverter table.
    log_q.delete();
    rom_download = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      rom_download = vecs[i].dl;
      ioctl_wr     = vecs[i].wr;
      ioctl_addr   = vecs[i].addr;
      ioctl_dout   = vecs[i].dout;
      tick();
      ioctl_wr = 1'b0;
      check($sformatf("prom_wr_%0d", i), 64'(prom_wr), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_wr) begin
        check($sformatf("prom_addr_%0d", i), 64'(prom_addr), 64'(vecs[i].exp_addr));
        check($sformatf("prom_data_%0d", i), 64'(prom_data), 64'(vecs[i].exp_data));
      end
      if (i < 5) check($sformatf("prom_no_req_%0d", i), 64'(sdram_req), 64'(0));
    end
    wait_log("prom_edge_count", 1, 40);
    check_log("prom_edge_w0", 0, exp_word(24'h07FFFF, 16'h0055, 2'b01));
    wait_loaded("prom_loaded", 30);

    // Overflow: ack withheld, 10 words offered, only the first 4 survive.
    ack_en = 1'b0;
    log_q.delete();
    rom_download = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) send_byte(25'(i), 8'(i));
    tick();
    check("ovf_flag", 64'(overflow), 64'(1));
    check("ovf_req_held", 64'(sdram_req), 64'(1));
    check("ovf_head_data", 64'(sdram_din), 64'(16'h0001));
    rom_download = 1'b0;
    ack_delay = 1;
    ack_en = 1'b1;
    wait_log("ovf_drain", 4, 80);
    repeat (20) tick();
    check("ovf_exact_count", 64'(log_q.size()), 64'(4));
    for (int k = 0; k < 4; k++)
      check_log($sformatf("ovf_w%0d", k), k,
                exp_word(24'(k), {8'(2*k), 8'(2*k+1)}, 2'b11));
    check("ovf_sticky", 64'(overflow), 64'(1));
    wait_loaded("ovf_loaded", 30);

    // Non-sequential odd byte discards the pending even byte.
    log_q.delete();
    rom_download = 1'b1;
    tick();
    check("rise_clears_ovf", 64'(overflow), 64'(0));
    check("rise_clears_loaded2", 64'(loaded), 64'(0));
    send_byte(25'd0, 8'h11);
    send_byte(25'd5, 8'h5A);
    check("seq_err_set", 64'(seq_err), 64'(1));
    rom_download = 1'b0;
    wait_log("seq_count", 1, 40);
    check_log("seq_w0", 0, exp_word(24'd2, 16'h005A, 2'b01));
    wait_loaded("seq_loaded", 30);
    repeat (5) tick();
    check("seq_no_extra", 64'(log_q.size()), 64'(1));
    rom_download = 1'b1;
    tick();
    check("rise_clears_seq_err", 64'(seq_err), 64'(0));
    check("rise_clears_loaded3", 64'(loaded), 64'(0));

    // Reset with a request outstanding and words queued.
    ack_en = 1'b0;
    log_q.delete();
    for (int i = 0; i < 5; i++) send_byte(25'(i), 8'(8'hA0 + i));
    send_byte(25'd7, 8'hB7);
    repeat (3) tick();
    check("pre_reset_req", 64'(sdram_req), 64'(1));
    check("pre_reset_seq_err", 64'(seq_err), 64'(1));
    reset = 1'b1;
    rom_download = 1'b0;
    tick();
    check("rst_req", 64'(sdram_req), 64'(0));
    check("rst_flags", 64'({loaded, overflow, seq_err}), 64'(0));
    check("rst_prom_wr", 64'(prom_wr), 64'(0));
    check("rst_ds", 64'(sdram_ds), 64'(0));
    reset = 1'b0;
    ack_en = 1'b1;
    repeat (20) tick();
    check("rst_fifo_empty", 64'(log_q.size()), 64'(0));
    check("rst_req_quiet", 64'(sdram_req), 64'(0));
    check("rst_not_loaded", 64'(loaded), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
